// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: turns valid/ready read/write commands into single
// non-pipelined Wishbone cycles and returns data/status on a valid/ready response channel.
module wb_master_bridge #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic            busy,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i
);

  // Counter is at least 1 bit wide so a disabled timeout still elaborates cleanly.
  localparam int unsigned   CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;
  logic          timeout_hit;
  logic          term;

  // Limit is reached on the edge that would make the count equal TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  assign term        = wbm_err_i || wbm_ack_i || timeout_hit;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          if (term) begin
            // err outranks ack; ack/err on the limit edge outranks the timeout.
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= wbm_err_i || !wbm_ack_i;
            rsp_timeout <= !wbm_err_i && !wbm_ack_i;
            rsp_dat     <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : '0;
            state       <= RESP;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: expected responses are queued at issue time
// and checked by a monitor when the response handshake occurs.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i, wbm_err_i;
  logic        sl_ack = 1'b0, sl_err = 1'b0, man_ack = 1'b0;

  assign wbm_ack_i = sl_ack | man_ack;
  assign wbm_err_i = sl_err;

  wb_master_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int mon_total = 0, mon_bad = 0;
  int edge_cnt = 0;
  int exp_rsp = 0, rsp_cnt = 0;
  int acc_cnt = 0, rise_cnt = 0, rsp_hs_cnt = 0;
  int stb_cnt = 0;
  logic adr_moved = 1'b0, rsp_prev = 1'b0;
  logic [31:0] adr_ref = '0, dat_ref = '0;
  logic we_ref = 1'b0;

  // slave model: mode 0 ack, 1 err, 2 ack+err, 3 silent; responds in stb cycle sl_wait
  int sl_mode = 0, sl_wait = 0, sl_cnt = 0;
  logic [31:0] sl_rdata = '0;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (sl_mode != 3) begin
      if (wbm_cyc_o && wbm_stb_o) begin
        if (sl_cnt == sl_wait) begin
          sl_ack    = (sl_mode == 0 || sl_mode == 2);
          sl_err    = (sl_mode == 1 || sl_mode == 2);
          wbm_dat_i = sl_rdata;
        end else begin
          sl_ack = 1'b0;
          sl_err = 1'b0;
        end
        sl_cnt++;
      end else begin
        sl_ack = 1'b0;
        sl_err = 1'b0;
        sl_cnt = 0;
      end
    end
  end

  task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    mon_total++;
    if (act !== exp) begin
      mon_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        acc_cnt   = edge_cnt;
        stb_cnt   = 0;
        adr_moved = 1'b0;
      end
      if (wbm_stb_o) begin
        if (stb_cnt == 0) begin
          adr_ref = wbm_adr_o;
          dat_ref = wbm_dat_o;
          we_ref  = wbm_we_o;
        end else if (wbm_adr_o !== adr_ref) begin
          adr_moved = 1'b1;
        end
        stb_cnt++;
      end
      if (rsp_valid && !rsp_prev) rise_cnt = edge_cnt;
      rsp_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_hs_cnt = edge_cnt;
        if (exp_q.size() == 0) begin
          mchk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          mchk("rsp_dat", rsp_dat, e.dat);
          mchk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          mchk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
        end
        rsp_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e, input logic t);
    exp_t x;
    x.dat = d; x.err = e; x.to = t;
    exp_q.push_back(x);
    exp_rsp++;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_cnt < exp_rsp && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_count", rsp_cnt, exp_rsp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap_dat;
    logic        snap_err;
    int n;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait write, slave drives junk read data
    sl_mode = 0; sl_wait = 0; sl_rdata = 32'hDEAD_BEEF;
    expect_rsp(32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    wait_rsp();
    chk("t1_stb_cycles", stb_cnt, 1);
    chk("t1_we", {31'd0, we_ref}, 32'd1);
    chk("t1_adr", adr_ref, 32'h3000_0004);
    chk("t1_wdat", dat_ref, 32'hA5A5_1234);
    chk("t1_latency", rise_cnt - acc_cnt, 2);

    // 2: read with 3 wait states
    sl_wait = 3; sl_rdata = 32'hCAFE_F00D;
    expect_rsp(32'hCAFE_F00D, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp();
    chk("t2_stb_cycles", stb_cnt, 4);
    chk("t2_adr_stable", {31'd0, adr_moved}, 32'd0);
    chk("t2_we", {31'd0, we_ref}, 32'd0);
    chk("t2_latency", rise_cnt - acc_cnt, 5);

    // 3: ack and err together, then err alone
    sl_mode = 2; sl_wait = 1; sl_rdata = 32'h1111_2222;
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    wait_rsp();
    sl_mode = 1; sl_wait = 0;
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(1'b0, 32'h3000_0010, 32'h0, 4'h3);
    wait_rsp();

    // 4: silent slave times out after 8 bus cycles; late ack ignored
    sl_mode = 3;
    expect_rsp(32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    wait_rsp();
    chk("t4_stb_cycles", stb_cnt, 8);
    man_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_late_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("t4_late_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t4_late_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t4_late_timeout_held", {30'd0, rsp_err, rsp_timeout}, 32'd3);
    chk("t4_late_rsp_count", rsp_cnt, exp_rsp);
    man_ack = 1'b0;

    // 5: response backpressure, new command waits for the rsp handshake
    sl_mode = 0; sl_wait = 0; sl_rdata = 32'h1234_5678;
    rsp_ready = 1'b0;
    expect_rsp(32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h3000_0018, 32'h5555_AAAA, 4'h1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    snap_dat = rsp_dat;
    snap_err = rsp_err;
    expect_rsp(32'h1234_5678, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_001C; cmd_sel = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_held_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t5_held_dat", rsp_dat, snap_dat);
    chk("t5_held_err", {31'd0, rsp_err}, {31'd0, snap_err});
    chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t5_no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("t5_accept_gap", acc_cnt - rsp_hs_cnt, 1);
    wait_rsp();

    // 6: reset mid-bus drops the cycle and produces no response
    sl_mode = 3;
    send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    @(posedge clk); #3;
    chk("t6_in_bus", {31'd0, wbm_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_no_rsp", rsp_cnt, exp_rsp);
    chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t6_idle_cyc", {31'd0, wbm_cyc_o}, 32'd0);

    // recovery after reset
    sl_mode = 0; sl_wait = 1; sl_rdata = 32'h0BAD_F00D;
    expect_rsp(32'h0BAD_F00D, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    wait_rsp();
    chk("t7_stb_cycles", stb_cnt, 2);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    total = total + mon_total;
    bad   = bad + mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
